// File: rtl/pa_f_spsram_init_param.sv
// Parametrised single-port SRAM wrapper with per-lane write enables, optional output
// register, hardware init sweep after reset or on request, read-valid and dropped-access pulses.
module pa_f_spsram_init_param #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    WEN_WIDTH  = 4,
  parameter int                    OUT_REG    = 0,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WEN_WIDTH-1:0]  WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVALID,
  output logic                  INIT_BUSY,
  output logic                  ACC_DROP
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANE  = DATA_WIDTH / WEN_WIDTH;

  generate
    if (DATA_WIDTH % WEN_WIDTH != 0) begin : g_bad_lane
      $error("pa_f_spsram_init_param: DATA_WIDTH must be a multiple of WEN_WIDTH");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_hold_reg;
  logic [DATA_WIDTH-1:0]   rd_data_reg;
  logic                    rd_vld_reg;
  logic                    acc_drop_reg;

  logic                    in_init;
  logic                    acc_wr;
  logic                    acc_rd;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [WEN_WIDTH-1:0]    lane_we;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (cnt_reg == {ADDR_WIDTH{1'b1}}) begin
          state_next = ST_READY;
        end else begin
          cnt_next = cnt_reg + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (INIT_REQ) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_READY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign in_init  = (state_reg == ST_INIT);
  assign acc_wr   = !in_init && !CEN && !GWEN;
  assign acc_rd   = !in_init && !CEN && GWEN;
  // The sweep owns the address port; otherwise idle cycles present the held address.
  assign mem_addr = in_init ? cnt_reg : (CEN ? addr_hold_reg : A);

  generate
    for (genvar gi = 0; gi < WEN_WIDTH; gi++) begin : g_lane
      assign lane_we[gi] = !RST && (in_init || (acc_wr && !WEN[gi]));
      assign wr_data[gi*LANE +: LANE] = in_init ? INIT_VAL[gi*LANE +: LANE] : D[gi*LANE +: LANE];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    for (int i = 0; i < WEN_WIDTH; i++) begin
      if (lane_we[i]) begin
        mem[mem_addr][i*LANE +: LANE] <= wr_data[i*LANE +: LANE];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_reg   <= '0;
      rd_vld_reg    <= 1'b0;
      addr_hold_reg <= '0;
      acc_drop_reg  <= 1'b0;
    end else begin
      rd_vld_reg   <= acc_rd;
      acc_drop_reg <= in_init && !CEN;
      if (acc_rd) begin
        rd_data_reg <= mem[mem_addr];
      end
      if (!CEN) begin
        addr_hold_reg <= A;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  qvalid_reg;

      // Advances on its own so a read issued just before a sweep still drains.
      always_ff @(posedge CLK) begin
        if (RST) begin
          q_reg      <= '0;
          qvalid_reg <= 1'b0;
        end else begin
          qvalid_reg <= rd_vld_reg;
          if (rd_vld_reg) begin
            q_reg <= rd_data_reg;
          end
        end
      end

      assign Q      = q_reg;
      assign QVALID = qvalid_reg;
    end else begin : g_no_out_reg
      assign Q      = rd_data_reg;
      assign QVALID = rd_vld_reg;
    end
  endgenerate

  assign INIT_BUSY = in_init;
  assign ACC_DROP  = acc_drop_reg;

endmodule
